// File: rtl/mips_if_pkg.sv
// Shared types for the MIPS32 instruction-fetch stage: NOP encoding, fetch-queue entry
// and fetch FSM states.
package mips_if_pkg;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO of fetch entries. Flush beats push, pop on empty is ignored, and a
// push alongside a pop is accepted even when full.
module if_fetch_queue
  import mips_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  fetch_entry_t slots [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = slots[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch unit: PC register, fetch FSM and redirect handling feeding a
// small fetch queue. Optional macro FETCH_BOUNDS_CHECK_EN adds the Fetch_Fault bounds check.
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_WORDS  = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] PC_IF,
  input  logic [31:0] Instruction_IF,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Halt,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC4_ID,
  output logic        Valid_ID,
  input  logic        Ready_ID
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic        Fetch_Fault
`endif
);

  // ID handshake: an entry transfers in any cycle where Valid_ID && Ready_ID at the rising
  // edge; Valid_ID never depends on Ready_ID, and a redirect does not void that transfer.

  logic [31:0]  pc;
  logic [31:0]  pc4;
  fetch_state_t state;
  logic         fetch;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         unused_target_lsbs;

  assign unused_target_lsbs = ^Branch_Target[1:0];
  assign pc4   = pc + 32'd4;
  assign PC_IF = {2'b00, pc[31:2]};
  assign pop   = !empty && Ready_ID;
  assign fetch = (state == S_RUN) && !Halt && !Branch_Taken && (!full || pop);

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault;
  logic out_of_range;
  logic fault_now;

  assign out_of_range     = ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));
  assign fault_now        = fetch && out_of_range;
  assign push_entry.instr = out_of_range ? MIPS_NOP : Instruction_IF;
  assign Fetch_Fault      = fault;
`else
  localparam int unused_imem_words = IMEM_WORDS;
  assign push_entry.instr = Instruction_IF;
`endif
  assign push_entry.pc4 = pc4;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc <= PC_RESET;
    end else if (Branch_Taken) begin
      pc <= {Branch_Target[31:2], 2'b00};
    end else if (fetch) begin
      pc <= pc4;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_BOOT;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault <= 1'b0;
`endif
    end else begin
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (Halt)  state <= S_HALT;
        S_HALT:  if (!Halt) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
`ifdef FETCH_BOUNDS_CHECK_EN
      // A bounds fault parks the FSM in S_HALT until the next reset.
      if (fault_now) fault <= 1'b1;
      if (fault_now || fault) state <= S_HALT;
`endif
    end
  end

  if_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (Clk),
    .rst      (Reset),
    .push     (fetch),
    .pop      (pop),
    .flush    (Branch_Taken),
    .push_data(push_entry),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign Valid_ID = !empty;
  assign Instr_ID = empty ? 32'h0 : head.instr;
  assign PC4_ID   = empty ? 32'h0 : head.pc4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch stage.
module tb_if_fetch_unit;

  localparam int D = 2;
  localparam int W = 1024;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC_IF;
  logic [31:0] Instruction_IF;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Halt;
  logic [31:0] Instr_ID;
  logic [31:0] PC4_ID;
  logic        Valid_ID;
  logic        Ready_ID;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        Fetch_Fault;
`endif

  if_fetch_unit #(
    .PC_RESET   (32'h0),
    .QUEUE_DEPTH(D),
    .IMEM_WORDS (W)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PC_IF         (PC_IF),
    .Instruction_IF(Instruction_IF),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Halt          (Halt),
    .Instr_ID      (Instr_ID),
    .PC4_ID        (PC4_ID),
    .Valid_ID      (Valid_ID),
    .Ready_ID      (Ready_ID)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .Fetch_Fault   (Fetch_Fault)
`endif
  );

  // Clock / memory
  always #5 Clk = ~Clk;

  logic [31:0] mem [0:W-1];
  assign Instruction_IF = mem[PC_IF[9:0]];

  // Reference model: queue of {instr, pc4}, byte PC, run/boot/fault flags
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_run;
  bit          m_fault;
  int          tests_run;
  int          tests_failed;

  task automatic init_mem_count();
    for (int k = 0; k < W; k++) mem[k] = k + 1;
  endtask

  task automatic init_mem_random();
    for (int k = 0; k < W; k++) mem[k] = $urandom;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = 32'h0;
    m_boot  = 1'b1;
    m_run   = 1'b0;
    m_fault = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, end on the next falling edge.
  task automatic step(input logic rdy, input logic hlt, input logic br, input logic [31:0] tgt);
    bit          hs;
    bit          fetch;
    logic [31:0] word;
    Ready_ID      = rdy;
    Halt          = hlt;
    Branch_Taken  = br;
    Branch_Target = tgt;
    hs    = (exp_q.size() > 0) && rdy;
    fetch = m_run && !hlt && !br && ((exp_q.size() < D) || hs);
    word  = mem[m_pc[11:2]];
`ifdef FETCH_BOUNDS_CHECK_EN
    if (fetch && ({2'b00, m_pc[31:2]} >= 32'(W))) begin
      word    = 32'h0;
      m_fault = 1'b1;
    end
`endif
    if (hs) void'(exp_q.pop_front());
    if (br) begin
      exp_q.delete();
      m_pc = {tgt[31:2], 2'b00};
    end else if (fetch) begin
      exp_q.push_back({word, m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
    m_run  = m_fault ? 1'b0 : (m_boot ? 1'b1 : !hlt);
    m_boot = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic logic [96:0] exp_out();
    logic [63:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
    return {exp_q.size() > 0, h, 2'b00, m_pc[31:2]};
  endfunction

  function automatic logic [96:0] obs_out();
    return {Valid_ID, (Valid_ID ? {Instr_ID, PC4_ID} : 64'h0), PC_IF};
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; Ready_ID = 1'b0; Halt = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1; Ready_ID = 1'b1; Halt = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0;
    @(negedge Clk);
    tests_run++;
    if ({Valid_ID, Instr_ID, PC4_ID, PC_IF} !== 97'h0) begin
      tests_failed++;
      $display("FAIL reset_values got v=%0b i=%h p=%h pc_if=%h want all zero", Valid_ID, Instr_ID, PC4_ID, PC_IF);
    end
`ifdef FETCH_BOUNDS_CHECK_EN
    tests_run++;
    if (Fetch_Fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fault got %b want 0", Fetch_Fault);
    end
`endif
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (i < 2) begin
        if (Valid_ID !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_latency cycle %0d got valid=%b want 0", i, Valid_ID);
        end
      end else if ({Valid_ID, Instr_ID, PC4_ID} !== {1'b1, 32'(i - 1), 32'(4 * (i - 1))}) begin
        tests_failed++;
        $display("FAIL stream_seq cycle %0d got v=%b i=%0d p=%0d want v=1 i=%0d p=%0d",
                 i, Valid_ID, Instr_ID, PC4_ID, i - 1, 4 * (i - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++;
    if (PC_IF !== 32'd2 || obs_out() !== exp_out()) begin
      tests_failed++;
      $display("FAIL bp_freeze got pc_if=%0d obs=%h want pc_if=2 exp=%h", PC_IF, obs_out(), exp_out());
    end
    nxt = 1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({Valid_ID, Instr_ID} !== {1'b1, 32'(nxt)}) begin
        tests_failed++;
        $display("FAIL bp_release got v=%b i=%0d want v=1 i=%0d", Valid_ID, Instr_ID, nxt);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      nxt++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    tests_run++;
    if ({Valid_ID, PC_IF} !== {1'b0, 32'd16}) begin
      tests_failed++;
      $display("FAIL branch_flush got v=%b pc_if=%0d want v=0 pc_if=16", Valid_ID, PC_IF);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    tests_run++;
    if ({Valid_ID, Instr_ID, PC4_ID} !== {1'b1, mem[16], 32'h44}) begin
      tests_failed++;
      $display("FAIL branch_target got v=%b i=%h p=%h want v=1 i=%h p=00000044", Valid_ID, Instr_ID, PC4_ID, mem[16]);
    end
    // Redirect while a handshake completes in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs_out() !== exp_out()) begin
        tests_failed++;
        $display("FAIL branch_handshake got %h want %h", obs_out(), exp_out());
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_halt();
    logic [31:0] held_pc;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    held_pc = PC_IF;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if ({Valid_ID, PC_IF} !== {1'b0, held_pc} || obs_out() !== exp_out()) begin
        tests_failed++;
        $display("FAIL halt_drain got v=%b pc_if=%0d want v=0 pc_if=%0d", Valid_ID, PC_IF, held_pc);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (obs_out() !== exp_out()) begin
        tests_failed++;
        $display("FAIL halt_resume got %h want %h", obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 Reset = 1'b1;
    #1;
    tests_run++;
    if ({Valid_ID, PC_IF} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL async_reset got v=%b pc_if=%0d want v=0 pc_if=0", Valid_ID, PC_IF);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (obs_out() !== exp_out()) begin
        tests_failed++;
        $display("FAIL async_restart got %h want %h", obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic        rdy;
    logic        hlt;
    logic        br;
    logic [31:0] tgt;
    init_mem_random();
    do_reset();
    hlt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) hlt = !hlt;
      br  = ($urandom_range(0, 19) == 0);
      tgt = {20'h0, 10'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3))};
`ifndef FETCH_BOUNDS_CHECK_EN
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
`endif
      step(rdy, hlt, br, tgt);
      tests_run++;
      if (obs_out() !== exp_out()) begin
        tests_failed++;
        $display("FAIL random cycle %0d got %h want %h", i, obs_out(), exp_out());
      end
    end
    init_mem_count();
  endtask

`ifdef FETCH_BOUNDS_CHECK_EN
  task automatic test_bounds();
    logic [31:0] held_pc;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'(W * 4));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    tests_run++;
    if ({Valid_ID, Instr_ID, Fetch_Fault} !== {1'b1, 32'h0, 1'b1} || obs_out() !== exp_out()) begin
      tests_failed++;
      $display("FAIL bounds_fault got v=%b i=%h f=%b want v=1 i=0 f=1", Valid_ID, Instr_ID, Fetch_Fault);
    end
    held_pc = PC_IF;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if ({Valid_ID, PC_IF, Fetch_Fault} !== {1'b0, held_pc, 1'b1}) begin
        tests_failed++;
        $display("FAIL bounds_stop got v=%b pc_if=%0d f=%b want v=0 pc_if=%0d f=1", Valid_ID, PC_IF, Fetch_Fault, held_pc);
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset = 1'b1; Ready_ID = 1'b0; Halt = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0;
    init_mem_count();
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_halt();
    test_async_reset();
`ifdef FETCH_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
